// File: rtl/movx_bus_ctrl.sv
// Purpose : External data-memory bus controller for 8051-style MOVX cycles
//           (multiplexed P0 address/data, P2 high address, ALE then RD_n/WR_n).
// Latency : ALE_CYCLES + STROBE_CYCLES + 2 busy cycles; done pulses in the last one.
// Backpressure: start is only accepted in IDLE; starts while busy are dropped, not queued.
//
// Ports:
//   i_clock    - system clock, rising edge
//   i_reset    - asynchronous reset, active low
//   i_start    - request pulse (sampled only while idle)
//   i_rw       - 1 = write (MOVX @x,A), 0 = read (MOVX A,@x)
//   i_use_dptr - 1 = address {i_dptr_h,i_dptr_l}, 0 = {i_p2_sfr,i_ri_addr}
//   i_dptr_h/l, i_ri_addr, i_p2_sfr, i_wdata - operands, captured on accept
//   i_p0_in    - P0 pad input, sampled at the end of a read strobe
//   o_busy, o_done, o_rdata - status / completion / last read byte
//   o_ale, o_rd_n, o_wr_n, o_p0_out, o_p0_oe, o_p2_out - pad-side bus signals
module movx_bus_ctrl #(
    parameter int unsigned ALE_CYCLES    = 1,   // legal 1..15
    parameter int unsigned STROBE_CYCLES = 3    // legal 1..15
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic       i_rw,
    input  logic       i_use_dptr,
    input  logic [7:0] i_dptr_h,
    input  logic [7:0] i_dptr_l,
    input  logic [7:0] i_ri_addr,
    input  logic [7:0] i_p2_sfr,
    input  logic [7:0] i_wdata,
    input  logic [7:0] i_p0_in,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_rdata,
    output logic       o_ale,
    output logic       o_rd_n,
    output logic       o_wr_n,
    output logic [7:0] o_p0_out,
    output logic       o_p0_oe,
    output logic [7:0] o_p2_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LATCH,
        S_STROBE,
        S_RECOVER
    } state_t;

    // The phase counter is loaded with N-1 on entry and the state exits at 0.
    localparam logic [3:0] ALE_LOAD    = 4'(ALE_CYCLES - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       w_capture;

    // Operands frozen for the whole bus cycle.
    logic [7:0] r_addr_hi;
    logic [7:0] r_addr_lo;
    logic       r_rw;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata;

    // Registered pad outputs.
    logic       r_ale;
    logic       r_rd_n;
    logic       r_wr_n;
    logic       r_p0_oe;
    logic [7:0] r_p0_out;
    logic       r_done;

    logic [7:0] w_addr_hi_in;
    logic [7:0] w_addr_lo_in;
    logic [7:0] w_addr_lo_eff;
    logic       w_rw_eff;
    logic [7:0] w_wdata_eff;

    logic       w_ale_nxt;
    logic       w_rd_n_nxt;
    logic       w_wr_n_nxt;
    logic       w_p0_oe_nxt;
    logic [7:0] w_p0_out_nxt;
    logic       w_done_nxt;

    assign w_addr_hi_in = i_use_dptr ? i_dptr_h : i_p2_sfr;
    assign w_addr_lo_in = i_use_dptr ? i_dptr_l : i_ri_addr;

    // Outputs are registered from the next state, so on the accepting edge the
    // freshly selected operands must be used rather than the stale registers.
    assign w_addr_lo_eff = w_capture ? w_addr_lo_in : r_addr_lo;
    assign w_rw_eff      = w_capture ? i_rw         : r_rw;
    assign w_wdata_eff   = w_capture ? i_wdata      : r_wdata;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_capture    = 1'b0;
        w_ale_nxt    = 1'b0;
        w_rd_n_nxt   = 1'b1;
        w_wr_n_nxt   = 1'b1;
        w_p0_oe_nxt  = 1'b0;
        w_p0_out_nxt = 8'h00;
        w_done_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_ADDR;
                    w_cnt_nxt   = ALE_LOAD;
                    w_capture   = 1'b1;
                end
            end
            S_ADDR: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_LATCH;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_LATCH: begin
                w_state_nxt = S_STROBE;
                w_cnt_nxt   = STROBE_LOAD;
            end
            S_STROBE: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RECOVER;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_RECOVER: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Decode the pad outputs for the state being entered.
        case (w_state_nxt)
            S_ADDR: begin
                w_ale_nxt    = 1'b1;
                w_p0_oe_nxt  = 1'b1;
                w_p0_out_nxt = w_addr_lo_eff;
            end
            S_LATCH: begin
                // Address held on P0 after ALE falls for the external latch.
                w_p0_oe_nxt  = 1'b1;
                w_p0_out_nxt = w_addr_lo_eff;
            end
            S_STROBE: begin
                w_rd_n_nxt = w_rw_eff;
                w_wr_n_nxt = !w_rw_eff;
                if (w_rw_eff) begin
                    w_p0_oe_nxt  = 1'b1;
                    w_p0_out_nxt = w_wdata_eff;
                end
            end
            S_RECOVER: begin
                w_done_nxt = 1'b1;
                // Write data held one cycle past the WR_n rising edge.
                if (w_rw_eff) begin
                    w_p0_oe_nxt  = 1'b1;
                    w_p0_out_nxt = w_wdata_eff;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_addr_hi <= 8'h00;
            r_addr_lo <= 8'h00;
            r_rw      <= 1'b0;
            r_wdata   <= 8'h00;
            r_rdata   <= 8'h00;
            r_ale     <= 1'b0;
            r_rd_n    <= 1'b1;
            r_wr_n    <= 1'b1;
            r_p0_oe   <= 1'b0;
            r_p0_out  <= 8'h00;
            r_done    <= 1'b0;
        end else begin
            if (w_capture) begin
                r_addr_hi <= w_addr_hi_in;
                r_addr_lo <= w_addr_lo_in;
                r_rw      <= i_rw;
                r_wdata   <= i_wdata;
            end
            // Read data is taken on the edge that ends the last strobe cycle.
            if (r_state == S_STROBE && r_cnt == 4'd0 && !r_rw) begin
                r_rdata <= i_p0_in;
            end
            r_ale    <= w_ale_nxt;
            r_rd_n   <= w_rd_n_nxt;
            r_wr_n   <= w_wr_n_nxt;
            r_p0_oe  <= w_p0_oe_nxt;
            r_p0_out <= w_p0_out_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign o_busy   = (r_state != S_IDLE);
    assign o_done   = r_done;
    assign o_rdata  = r_rdata;
    assign o_ale    = r_ale;
    assign o_rd_n   = r_rd_n;
    assign o_wr_n   = r_wr_n;
    assign o_p0_oe  = r_p0_oe;
    assign o_p0_out = r_p0_out;
    // P2 follows the SFR latch when idle, the captured high address otherwise.
    assign o_p2_out = (r_state == S_IDLE) ? i_p2_sfr : r_addr_hi;

endmodule

// File: doc/movx_bus_ctrl.md
# movx_bus_ctrl

External data-memory bus controller for MOVX cycles. Consumes the 16-bit data pointer (DPTR high/low bytes from the DPTR SFR) or an 8-bit @Ri address with the P2 SFR as page. Runs one multiplexed 8051-style external bus cycle: ALE address phase, then RD_n/WR_n strobe. Sits between the instruction execution control and the P0/P2 port pads.

## Interface
Parameters:
- ALE_CYCLES, 1, cycles ALE is held high in the address phase (legal 1..15)
- STROBE_CYCLES, 3, cycles RD_n/WR_n are held low (legal 1..15)

Ports:
- clock  input  1  system clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  request pulse; accepted only while idle
- rw  input  1  1 = write (MOVX @x,A), 0 = read (MOVX A,@x)
- use_dptr  input  1  1 = address {dptr_h,dptr_l}; 0 = address {p2_sfr,ri_addr}
- dptr_h  input  8  DPTR high byte
- dptr_l  input  8  DPTR low byte
- ri_addr  input  8  R0/R1 contents
- p2_sfr  input  8  P2 SFR latch value
- wdata  input  8  accumulator value to write
- p0_in  input  8  P0 pad input
- busy  output  1  high while a bus cycle is in progress
- done  output  1  one-cycle completion pulse
- rdata  output  8  last read byte
- ale  output  1  address latch enable
- rd_n  output  1  read strobe, active low
- wr_n  output  1  write strobe, active low
- p0_out  output  8  P0 drive value
- p0_oe  output  1  P0 output enable
- p2_out  output  8  P2 drive value

## Operation
- FSM states: IDLE, ADDR, LATCH, STROBE, RECOVER; 4-bit phase counter.
- IDLE:
  - busy=0, ale=0, rd_n=wr_n=1, p0_oe=0, p0_out=0.
  - p2_out = p2_sfr (combinational pass-through).
  - start=1 captures addr_hi/addr_lo (mux on use_dptr), rw and wdata into internal registers.
  - Go to ADDR.
- ADDR (ALE_CYCLES cycles): ale=1, p0_oe=1, p0_out=addr_lo, p2_out=addr_hi.
- LATCH (1 cycle): ale=0; address still driven on P0/P2 (hold time).
- STROBE (STROBE_CYCLES cycles): p2_out=addr_hi.
  - Write: wr_n=0, p0_oe=1, p0_out=wdata.
  - Read: rd_n=0, p0_oe=0, p0_out=0. p0_in is registered into rdata on the clock edge ending the last STROBE cycle.
- RECOVER (1 cycle): rd_n=wr_n=1, done=1, busy=1.
  - Write: p0_oe=1 and wdata still driven (data hold).
  - Read: p0_oe=0.
  - Next state is IDLE.
- busy=1 in every state except IDLE.
- Captured operands are frozen for the whole cycle. Changes on dptr_*, ri_addr, p2_sfr or wdata after acceptance have no effect until the next start.
- start while busy (including RECOVER) is ignored and not queued.
- rdata holds its value until the next read completes. Write cycles never modify it.
- ale, rd_n, wr_n, p0_oe, p0_out and done are registered (decoded from state registers). rd_n and wr_n are never low in the same cycle.

## Timing
- Reset (reset=0, asynchronous): state IDLE, busy=0, done=0, rdata=8'h00, ale=0, rd_n=1, wr_n=1, p0_oe=0, p0_out=8'h00, p2_out=p2_sfr.
- Reset asserted mid-cycle: strobes deassert immediately and no done pulse is produced. On release, the block starts in IDLE.
- Let edge 0 be the edge that samples start=1 in IDLE.
  - ADDR occupies cycles 1..ALE_CYCLES.
  - LATCH is cycle ALE_CYCLES+1.
  - STROBE occupies cycles ALE_CYCLES+2 .. ALE_CYCLES+STROBE_CYCLES+1.
  - RECOVER (done=1) is cycle ALE_CYCLES+STROBE_CYCLES+2.
  - busy falls and a new start is accepted on the next edge.
- Defaults: 6 busy cycles per transfer, back-to-back throughput of one transfer per 7 clocks. The next start is sampled in the first IDLE cycle.
- The counter loads N-1 on state entry and the FSM exits the state at 0. Parameter values outside 1..15 are illegal.

## Test plan
- Reset values: hold reset=0 with p2_sfr=8'h5A → every output at its reset value, p2_out=8'h5A. Release reset → no spurious done.
- DPTR write: dptr=16'h12F0, wdata=8'hA5, rw=1, use_dptr=1, pulse start → ale=1 for 1 cycle with p0_out=F0/p2_out=12; then 1 LATCH cycle; wr_n=0 for 3 cycles with p0_out=A5; done in cycle 6; busy low in cycle 7.
- @Ri read: p2_sfr=8'h80, ri_addr=8'h33, p0_in=8'h6C during strobe → address 8033 on the bus; rd_n low 3 cycles with p0_oe=0; rdata=8'h6C at done.
- Operand freeze and ignored start: change dptr to 16'hFFFF and pulse start during STROBE → bus keeps 12F0; only one done pulse is produced.
- Reset mid-cycle: assert reset during the 2nd STROBE cycle of a read → rd_n=1 immediately, rdata stays 8'h00, no done.
- Parameter sweep: ALE_CYCLES=2, STROBE_CYCLES=1 → done on cycle 5. Back-to-back starts, each issued on the first idle cycle → no overlap of rd_n and wr_n.
